// File: rtl/axi4_lite_cmd_master.sv
// axi4_lite_cmd_master
// Purpose: AXI4-lite initiator. Turns a single-beat command/response handshake port
// into AXI4-lite master transactions, one transaction outstanding at a time,
// with an optional response timeout.
// Parameters:
//   A        address bits
//   N        data bytes
//   I        id bits (0 = no id; awid/arid are then 1 bit wide and driven 0)
//   ID       value driven on awid/arid when I > 0
//   TIMEOUT  cycles from command accept to B/R handshake before abort; 0 = disabled
// Ports:
//   aclk, areset                 clock, asynchronous active-high reset
//   cmd_valid/cmd_ready          command handshake
//   cmd_write/addr/wdata/wstrb   command payload (wdata/wstrb ignored for reads)
//   rsp_valid/rsp_ready          response handshake
//   rsp_write/rdata/resp/timeout response payload
//   axi4_m_*                     AXI4-lite master channels (AW, W, B, AR, R)
module axi4_lite_cmd_master #(
    parameter int A       = 32,
    parameter int N       = 4,
    parameter int I       = 0,
    parameter int ID      = 0,
    parameter int TIMEOUT = 0,
    localparam int IW     = (I > 0) ? I : 1
) (
    input  logic            aclk,
    input  logic            areset,
    // command port
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_write,
    input  logic [A-1:0]    cmd_addr,
    input  logic [N*8-1:0]  cmd_wdata,
    input  logic [N-1:0]    cmd_wstrb,
    // response port
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_write,
    output logic [N*8-1:0]  rsp_rdata,
    output logic [1:0]      rsp_resp,
    output logic            rsp_timeout,
    // AXI4-lite write address channel
    output logic            axi4_m_awvalid,
    input  logic            axi4_m_awready,
    output logic [A-1:0]    axi4_m_awaddr,
    output logic [2:0]      axi4_m_awprot,
    output logic [IW-1:0]   axi4_m_awid,
    // write data channel
    output logic            axi4_m_wvalid,
    input  logic            axi4_m_wready,
    output logic [N*8-1:0]  axi4_m_wdata,
    output logic [N-1:0]    axi4_m_wstrb,
    // write response channel
    input  logic            axi4_m_bvalid,
    output logic            axi4_m_bready,
    input  logic [1:0]      axi4_m_bresp,
    input  logic [IW-1:0]   axi4_m_bid,
    // read address channel
    output logic            axi4_m_arvalid,
    input  logic            axi4_m_arready,
    output logic [A-1:0]    axi4_m_araddr,
    output logic [2:0]      axi4_m_arprot,
    output logic [IW-1:0]   axi4_m_arid,
    // read data channel
    input  logic            axi4_m_rvalid,
    output logic            axi4_m_rready,
    input  logic [N*8-1:0]  axi4_m_rdata,
    input  logic [1:0]      axi4_m_rresp,
    input  logic [IW-1:0]   axi4_m_rid
);

    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WADDR,
        S_WRESP,
        S_RADDR,
        S_RRESP,
        S_RSP,
        S_DRAIN
    } state_t;

    state_t          r_state;
    logic            r_awvalid;
    logic            r_wvalid;
    logic            r_arvalid;
    logic            r_bready;
    logic            r_rready;
    logic [A-1:0]    r_addr;
    logic [N*8-1:0]  r_wdata;
    logic [N-1:0]    r_wstrb;
    logic            r_write;
    logic            r_abort;
    logic [TW-1:0]   r_timer;
    logic            r_rsp_valid;
    logic [N*8-1:0]  r_rsp_rdata;
    logic [1:0]      r_rsp_resp;
    logic            r_rsp_timeout;

    logic            w_bhs;
    logic            w_rhs;
    logic            w_aw_done;
    logic            w_w_done;
    logic            w_busy;
    logic            w_expired;
    logic            w_abort;
    logic            w_unused;

    // bid/rid carry no information for a single-outstanding initiator
    assign w_unused = ^{axi4_m_bid, axi4_m_rid};

    assign w_bhs     = r_bready & axi4_m_bvalid;
    assign w_rhs     = r_rready & axi4_m_rvalid;
    // A channel is done once its valid has already dropped or handshakes this cycle
    assign w_aw_done = ~r_awvalid | axi4_m_awready;
    assign w_w_done  = ~r_wvalid  | axi4_m_wready;
    assign w_busy    = (r_state == S_WADDR) || (r_state == S_WRESP) ||
                       (r_state == S_RADDR) || (r_state == S_RRESP);
    assign w_expired = (TIMEOUT != 0) && (r_timer == TW'(TIMEOUT));
    // A B/R handshake in the expiry cycle takes priority over the abort
    assign w_abort   = w_busy && w_expired && !w_bhs && !w_rhs;

    assign cmd_ready      = (r_state == S_IDLE);

    assign rsp_valid      = r_rsp_valid;
    assign rsp_write      = r_write;
    assign rsp_rdata      = r_rsp_rdata;
    assign rsp_resp       = r_rsp_resp;
    assign rsp_timeout    = r_rsp_timeout;

    assign axi4_m_awvalid = r_awvalid;
    assign axi4_m_awaddr  = r_addr;
    assign axi4_m_awprot  = 3'b000;
    assign axi4_m_awid    = (I > 0) ? IW'(ID) : '0;
    assign axi4_m_wvalid  = r_wvalid;
    assign axi4_m_wdata   = r_wdata;
    assign axi4_m_wstrb   = r_wstrb;
    assign axi4_m_bready  = r_bready;
    assign axi4_m_arvalid = r_arvalid;
    assign axi4_m_araddr  = r_addr;
    assign axi4_m_arprot  = 3'b000;
    assign axi4_m_arid    = (I > 0) ? IW'(ID) : '0;
    assign axi4_m_rready  = r_rready;

    // Transaction FSM. Address/data valids are dropped only by their own handshake,
    // in every state, so a transaction aborted by the timer keeps its pending
    // valids up through RSP and DRAIN until the responder takes them.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state       <= S_IDLE;
            r_awvalid     <= 1'b0;
            r_wvalid      <= 1'b0;
            r_arvalid     <= 1'b0;
            r_bready      <= 1'b0;
            r_rready      <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_wstrb       <= '0;
            r_write       <= 1'b0;
            r_abort       <= 1'b0;
            r_timer       <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_resp    <= 2'b00;
            r_rsp_timeout <= 1'b0;
        end else begin
            if (r_awvalid && axi4_m_awready) r_awvalid <= 1'b0;
            if (r_wvalid  && axi4_m_wready)  r_wvalid  <= 1'b0;
            if (r_arvalid && axi4_m_arready) r_arvalid <= 1'b0;
            if (w_busy) r_timer <= r_timer + 1'b1;

            if (w_abort) begin
                r_state       <= S_RSP;
                r_abort       <= 1'b1;
                r_bready      <= 1'b0;
                r_rready      <= 1'b0;
                r_rsp_valid   <= 1'b1;
                r_rsp_rdata   <= '0;
                r_rsp_resp    <= 2'b10;
                r_rsp_timeout <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (cmd_valid) begin
                            r_addr  <= cmd_addr;
                            r_wdata <= cmd_wdata;
                            r_wstrb <= cmd_wstrb;
                            r_write <= cmd_write;
                            r_abort <= 1'b0;
                            r_timer <= '0;
                            if (cmd_write) begin
                                r_awvalid <= 1'b1;
                                r_wvalid  <= 1'b1;
                                r_state   <= S_WADDR;
                            end else begin
                                r_arvalid <= 1'b1;
                                r_state   <= S_RADDR;
                            end
                        end
                    end
                    S_WADDR: begin
                        if (w_aw_done && w_w_done) begin
                            r_bready <= 1'b1;
                            r_state  <= S_WRESP;
                        end
                    end
                    S_WRESP: begin
                        if (w_bhs) begin
                            r_bready      <= 1'b0;
                            r_rsp_valid   <= 1'b1;
                            r_rsp_rdata   <= '0;
                            r_rsp_resp    <= axi4_m_bresp;
                            r_rsp_timeout <= 1'b0;
                            r_state       <= S_RSP;
                        end
                    end
                    S_RADDR: begin
                        if (axi4_m_arready) begin
                            r_rready <= 1'b1;
                            r_state  <= S_RRESP;
                        end
                    end
                    S_RRESP: begin
                        if (w_rhs) begin
                            r_rready      <= 1'b0;
                            r_rsp_valid   <= 1'b1;
                            r_rsp_rdata   <= axi4_m_rdata;
                            r_rsp_resp    <= axi4_m_rresp;
                            r_rsp_timeout <= 1'b0;
                            r_state       <= S_RSP;
                        end
                    end
                    S_RSP: begin
                        if (rsp_ready) begin
                            r_rsp_valid <= 1'b0;
                            if (r_abort) begin
                                // the late response is still owed; swallow it in DRAIN
                                r_bready <= r_write;
                                r_rready <= ~r_write;
                                r_state  <= S_DRAIN;
                            end else begin
                                r_state  <= S_IDLE;
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (w_bhs || w_rhs) begin
                            r_bready <= 1'b0;
                            r_rready <= 1'b0;
                            r_abort  <= 1'b0;
                            r_state  <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_axi4_lite_cmd_master.sv
// tb_axi4_lite_cmd_master
// Purpose: directed self-checking bench for axi4_lite_cmd_master with TIMEOUT = 8.
// The bench plays the AXI4-lite responder by hand, one directed step at a time.
module tb_axi4_lite_cmd_master;

    localparam int A       = 32;
    localparam int N       = 4;
    localparam int I       = 4;
    localparam int ID      = 5;
    localparam int TIMEOUT = 8;

    logic            aclk;
    logic            areset;
    logic            cmd_valid;
    logic            cmd_ready;
    logic            cmd_write;
    logic [A-1:0]    cmd_addr;
    logic [N*8-1:0]  cmd_wdata;
    logic [N-1:0]    cmd_wstrb;
    logic            rsp_valid;
    logic            rsp_ready;
    logic            rsp_write;
    logic [N*8-1:0]  rsp_rdata;
    logic [1:0]      rsp_resp;
    logic            rsp_timeout;
    logic            awvalid;
    logic            awready;
    logic [A-1:0]    awaddr;
    logic [2:0]      awprot;
    logic [I-1:0]    awid;
    logic            wvalid;
    logic            wready;
    logic [N*8-1:0]  wdata;
    logic [N-1:0]    wstrb;
    logic            bvalid;
    logic            bready;
    logic [1:0]      bresp;
    logic [I-1:0]    bid;
    logic            arvalid;
    logic            arready;
    logic [A-1:0]    araddr;
    logic [2:0]      arprot;
    logic [I-1:0]    arid;
    logic            rvalid;
    logic            rready;
    logic [N*8-1:0]  rdata;
    logic [1:0]      rresp;
    logic [I-1:0]    rid;

    int nAsserts = 0;
    int nFail    = 0;

    axi4_lite_cmd_master #(
        .A       (A),
        .N       (N),
        .I       (I),
        .ID      (ID),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .aclk           (aclk),
        .areset         (areset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_write      (cmd_write),
        .cmd_addr       (cmd_addr),
        .cmd_wdata      (cmd_wdata),
        .cmd_wstrb      (cmd_wstrb),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_write      (rsp_write),
        .rsp_rdata      (rsp_rdata),
        .rsp_resp       (rsp_resp),
        .rsp_timeout    (rsp_timeout),
        .axi4_m_awvalid (awvalid),
        .axi4_m_awready (awready),
        .axi4_m_awaddr  (awaddr),
        .axi4_m_awprot  (awprot),
        .axi4_m_awid    (awid),
        .axi4_m_wvalid  (wvalid),
        .axi4_m_wready  (wready),
        .axi4_m_wdata   (wdata),
        .axi4_m_wstrb   (wstrb),
        .axi4_m_bvalid  (bvalid),
        .axi4_m_bready  (bready),
        .axi4_m_bresp   (bresp),
        .axi4_m_bid     (bid),
        .axi4_m_arvalid (arvalid),
        .axi4_m_arready (arready),
        .axi4_m_araddr  (araddr),
        .axi4_m_arprot  (arprot),
        .axi4_m_arid    (arid),
        .axi4_m_rvalid  (rvalid),
        .axi4_m_rready  (rready),
        .axi4_m_rdata   (rdata),
        .axi4_m_rresp   (rresp),
        .axi4_m_rid     (rid)
    );

    // 100 MHz clock
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Compare one observed value against its hand-computed expectation
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        nAsserts++;
        assert (observed === expected)
        else begin
            nFail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic waitCycle();
        @(posedge aclk);
        #1;
    endtask

    // Offer a command on the command port
    task automatic applyStimulus(input logic wr, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [3:0] strb);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = data;
        cmd_wstrb = strb;
    endtask

    // Directed sequence
    initial begin
        areset    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_wstrb = '0;
        rsp_ready = 1'b0;
        awready   = 1'b0;
        wready    = 1'b0;
        bvalid    = 1'b0;
        bresp     = 2'b00;
        bid       = '0;
        arready   = 1'b0;
        rvalid    = 1'b0;
        rdata     = '0;
        rresp     = 2'b00;
        rid       = '0;

        // ---- reset ----
        repeat (2) waitCycle();
        checkOutput("reset_awvalid", awvalid, 0);
        checkOutput("reset_wvalid", wvalid, 0);
        checkOutput("reset_arvalid", arvalid, 0);
        checkOutput("reset_rsp_valid", rsp_valid, 0);
        areset = 1'b0;
        waitCycle();
        checkOutput("reset_cmd_ready", cmd_ready, 1);
        checkOutput("reset_bready", bready, 0);
        checkOutput("reset_rready", rready, 0);
        checkOutput("reset_rsp_rdata", rsp_rdata, 0);

        // ---- write 0x10, zero-latency responder ----
        awready = 1'b1;
        wready  = 1'b1;
        applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        waitCycle();
        cmd_valid = 1'b0;
        checkOutput("w1_awvalid", awvalid, 1);
        checkOutput("w1_wvalid", wvalid, 1);
        checkOutput("w1_awaddr", awaddr, 32'h10);
        checkOutput("w1_wdata", wdata, 32'hDEADBEEF);
        checkOutput("w1_wstrb", wstrb, 4'hF);
        checkOutput("w1_awprot", awprot, 0);
        checkOutput("w1_awid", awid, ID);
        checkOutput("w1_cmd_ready", cmd_ready, 0);
        waitCycle();
        checkOutput("w1_awvalid_drop", awvalid, 0);
        checkOutput("w1_wvalid_drop", wvalid, 0);
        checkOutput("w1_bready", bready, 1);
        bvalid = 1'b1;
        bresp  = 2'b00;
        waitCycle();
        bvalid = 1'b0;
        checkOutput("w1_rsp_valid", rsp_valid, 1);
        checkOutput("w1_rsp_resp", rsp_resp, 2'b00);
        checkOutput("w1_rsp_write", rsp_write, 1);
        checkOutput("w1_rsp_timeout", rsp_timeout, 0);
        checkOutput("w1_bready_rsp", bready, 0);
        rsp_ready = 1'b1;
        waitCycle();
        rsp_ready = 1'b0;
        checkOutput("w1_rsp_done", rsp_valid, 0);
        checkOutput("w1_cmd_ready_idle", cmd_ready, 1);

        // ---- write with awready 3 cycles before wready ----
        awready = 1'b1;
        wready  = 1'b0;
        applyStimulus(1'b1, 32'h44, 32'h12345678, 4'h3);
        waitCycle();
        cmd_valid = 1'b0;
        checkOutput("w2_awvalid", awvalid, 1);
        waitCycle();
        awready = 1'b0;
        checkOutput("w2_awvalid_drop", awvalid, 0);
        checkOutput("w2_wvalid_held1", wvalid, 1);
        waitCycle();
        checkOutput("w2_wvalid_held2", wvalid, 1);
        waitCycle();
        checkOutput("w2_wvalid_held3", wvalid, 1);
        checkOutput("w2_bready_early", bready, 0);
        wready = 1'b1;
        waitCycle();
        wready = 1'b0;
        checkOutput("w2_wvalid_drop", wvalid, 0);
        checkOutput("w2_awvalid_low", awvalid, 0);
        checkOutput("w2_bready", bready, 1);
        bvalid = 1'b1;
        bresp  = 2'b01;
        waitCycle();
        bvalid = 1'b0;
        checkOutput("w2_rsp_valid", rsp_valid, 1);
        checkOutput("w2_rsp_resp", rsp_resp, 2'b01);
        checkOutput("w2_bready_after_b", bready, 0);
        rsp_ready = 1'b1;
        waitCycle();
        rsp_ready = 1'b0;
        checkOutput("w2_cmd_ready", cmd_ready, 1);

        // ---- read 0x20 returning 0xBAADC0DE ----
        applyStimulus(1'b0, 32'h20, 32'h55555555, 4'h0);
        waitCycle();
        cmd_valid = 1'b0;
        checkOutput("r1_arvalid", arvalid, 1);
        checkOutput("r1_araddr", araddr, 32'h20);
        checkOutput("r1_arid", arid, ID);
        checkOutput("r1_awvalid", awvalid, 0);
        checkOutput("r1_rready_early", rready, 0);
        waitCycle();
        checkOutput("r1_arvalid_held", arvalid, 1);
        arready = 1'b1;
        waitCycle();
        arready = 1'b0;
        checkOutput("r1_arvalid_drop", arvalid, 0);
        checkOutput("r1_rready", rready, 1);
        rvalid = 1'b1;
        rdata  = 32'hBAADC0DE;
        rresp  = 2'b00;
        waitCycle();
        rvalid = 1'b0;
        rdata  = 32'h0;
        checkOutput("r1_rsp_valid", rsp_valid, 1);
        checkOutput("r1_rsp_rdata", rsp_rdata, 32'hBAADC0DE);
        checkOutput("r1_rsp_resp", rsp_resp, 2'b00);
        checkOutput("r1_rsp_write", rsp_write, 0);
        checkOutput("r1_rready_rsp", rready, 0);

        // ---- rsp_ready held low 5 cycles while a new write waits ----
        awready = 1'b1;
        wready  = 1'b1;
        applyStimulus(1'b1, 32'h80, 32'h0BADF00D, 4'hF);
        for (int k = 0; k < 5; k++) begin
            waitCycle();
            checkOutput("stall_rsp_valid", rsp_valid, 1);
            checkOutput("stall_rsp_rdata", rsp_rdata, 32'hBAADC0DE);
            checkOutput("stall_cmd_ready", cmd_ready, 0);
            checkOutput("stall_awvalid", awvalid, 0);
        end
        rsp_ready = 1'b1;
        waitCycle();
        rsp_ready = 1'b0;
        checkOutput("stall_rsp_done", rsp_valid, 0);
        checkOutput("stall_cmd_ready_after", cmd_ready, 1);
        checkOutput("stall_no_early_accept", awvalid, 0);

        // ---- the waiting write is accepted now; responder never answers B ----
        waitCycle();
        cmd_valid = 1'b0;
        checkOutput("to_accept_awvalid", awvalid, 1);
        checkOutput("to_awaddr", awaddr, 32'h80);
        repeat (8) waitCycle();
        checkOutput("to_before_expiry", rsp_valid, 0);
        checkOutput("to_bready_waiting", bready, 1);
        waitCycle();
        checkOutput("to_rsp_valid", rsp_valid, 1);
        checkOutput("to_rsp_timeout", rsp_timeout, 1);
        checkOutput("to_rsp_resp", rsp_resp, 2'b10);
        checkOutput("to_rsp_rdata", rsp_rdata, 0);
        checkOutput("to_bready_rsp", bready, 0);
        bvalid = 1'b1;
        bresp  = 2'b00;
        waitCycle();
        checkOutput("to_rsp_hold", rsp_valid, 1);
        checkOutput("to_b_not_taken_in_rsp", bready, 0);
        rsp_ready = 1'b1;
        waitCycle();
        rsp_ready = 1'b0;
        checkOutput("drain_bready", bready, 1);
        checkOutput("drain_cmd_ready", cmd_ready, 0);
        checkOutput("drain_rsp_valid", rsp_valid, 0);
        waitCycle();
        bvalid = 1'b0;
        checkOutput("drain_done_cmd_ready", cmd_ready, 1);
        checkOutput("drain_done_bready", bready, 0);
        checkOutput("drain_no_rsp", rsp_valid, 0);

        // ---- B handshake in the expiry cycle wins over the abort ----
        applyStimulus(1'b1, 32'h30, 32'hCAFEF00D, 4'hC);
        waitCycle();
        cmd_valid = 1'b0;
        repeat (8) waitCycle();
        checkOutput("tie_before", rsp_valid, 0);
        bvalid = 1'b1;
        bresp  = 2'b00;
        waitCycle();
        bvalid = 1'b0;
        checkOutput("tie_rsp_valid", rsp_valid, 1);
        checkOutput("tie_rsp_timeout", rsp_timeout, 0);
        checkOutput("tie_rsp_resp", rsp_resp, 2'b00);
        rsp_ready = 1'b1;
        waitCycle();
        rsp_ready = 1'b0;
        checkOutput("tie_back_to_idle", cmd_ready, 1);
        checkOutput("tie_no_drain", bready, 0);

        // ---- areset asserted in WADDR ----
        awready = 1'b0;
        wready  = 1'b0;
        applyStimulus(1'b1, 32'h90, 32'h11223344, 4'hF);
        waitCycle();
        cmd_valid = 1'b0;
        checkOutput("rst_awvalid_before", awvalid, 1);
        checkOutput("rst_wvalid_before", wvalid, 1);
        #2;
        areset = 1'b1;
        #1;
        checkOutput("rst_async_awvalid", awvalid, 0);
        checkOutput("rst_async_wvalid", wvalid, 0);
        waitCycle();
        areset = 1'b0;
        waitCycle();
        checkOutput("rst_release_cmd_ready", cmd_ready, 1);
        checkOutput("rst_release_awvalid", awvalid, 0);
        checkOutput("rst_release_rsp_valid", rsp_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule
